// File: rtl/safe_zone_pkg.sv
// Shared types and width helpers for the safe_zone map block and its controller.
package safe_zone_pkg;

    typedef enum logic [1:0] {
        READY = 2'd0,
        KICK  = 2'd1,
        ARM   = 2'd2,
        GEN   = 2'd3
    } szc_state_t;

    function automatic int x_width(input int screen_width);
        return $clog2(screen_width);
    endfunction

    function automatic int y_width(input int screen_height);
        return $clog2(screen_height);
    endfunction

endpackage

// File: rtl/safe_zone_ctrl_if.sv
// Link between the controller and the safe_zone map: regeneration kick, ready flag, query port.
interface safe_zone_ctrl_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           o_regen;
    logic           i_zone_rdy;
    logic [X_W-1:0] o_zone_x;
    logic [Y_W-1:0] o_zone_y;
    logic           i_zone_safe;

    // o_regen is a one-cycle pulse; i_zone_safe is combinational in o_zone_x/o_zone_y.
    modport master (
        output o_regen,
        output o_zone_x,
        output o_zone_y,
        input  i_zone_rdy,
        input  i_zone_safe
    );

    modport slave (
        input  o_regen,
        input  o_zone_x,
        input  o_zone_y,
        output i_zone_rdy,
        output i_zone_safe
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-port round-robin arbiter; the pointer remembers the last granted port.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       arst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);
    logic ptr_q;
    logic ptr_d;

    // Pointer resets to 1 so that port 0 wins the first contested cycle.
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                o_gnt = ptr_q ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (o_gnt != 2'b00) begin
            ptr_d = o_gnt[1];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/safe_zone_ctrl.sv
// Level-regeneration sequencer and two-requester query arbiter in front of safe_zone.
module safe_zone_ctrl
    import safe_zone_pkg::*;
#(
    parameter  int SCREEN_WIDTH  = 800,
    parameter  int SCREEN_HEIGHT = 600,
    parameter  int LEVEL_W       = 8,
    parameter  int ARM_TIMEOUT   = 4,
    localparam int X_W           = x_width(SCREEN_WIDTH),
    localparam int Y_W           = y_width(SCREEN_HEIGHT)
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               i_new_level,
    safe_zone_ctrl_if.master   zone,
    input  logic [1:0]         i_req,
    input  logic [X_W-1:0]     i_x0,
    input  logic [X_W-1:0]     i_x1,
    input  logic [Y_W-1:0]     i_y0,
    input  logic [Y_W-1:0]     i_y1,
    output logic [1:0]         o_gnt,
    output logic [1:0]         o_rsp_valid,
    output logic               o_rsp_safe,
    output logic               o_ready,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_err,
    output szc_state_t         o_dbg_state
);
    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_KICK  = 2'd1;
    localparam logic [1:0] ST_ARM   = 2'd2;
    localparam logic [1:0] ST_GEN   = 2'd3;

    localparam int             CNT_W     = $clog2(ARM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] ARM_LIMIT = CNT_W'(ARM_TIMEOUT);

    logic [1:0]         state_q, state_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   arm_cnt_q, arm_cnt_d;
    logic [CNT_W-1:0]   arm_cnt_inc;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               err_q, err_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic               rsp_safe_q, rsp_safe_d;
    logic [1:0]         gnt;
    logic               arb_en;

    assign arm_cnt_inc = arm_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        arm_cnt_d = arm_cnt_q;
        level_d   = level_q;
        err_d     = err_q;
        case (state_q)
            ST_READY: begin
                if (i_new_level) begin
                    state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                if (i_new_level) begin
                    pend_d = 1'b1;
                end
                arm_cnt_d = '0;
                state_d   = ST_ARM;
            end
            ST_ARM: begin
                if (i_new_level) begin
                    pend_d = 1'b1;
                end
                if (!zone.i_zone_rdy) begin
                    state_d = ST_GEN;
                end else begin
                    arm_cnt_d = arm_cnt_inc;
                    // The map never acknowledged the kick; give up and count the level anyway.
                    if (arm_cnt_inc == ARM_LIMIT) begin
                        err_d   = 1'b1;
                        level_d = level_q + 1'b1;
                        state_d = ST_READY;
                    end
                end
            end
            ST_GEN: begin
                if (i_new_level) begin
                    pend_d = 1'b1;
                end
                if (zone.i_zone_rdy) begin
                    level_d = level_q + 1'b1;
                    if (pend_q || i_new_level) begin
                        pend_d  = 1'b0;
                        state_d = ST_KICK;
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end
            default: begin
                state_d = ST_KICK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_KICK;
            pend_q    <= 1'b0;
            arm_cnt_q <= '0;
            level_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            arm_cnt_q <= arm_cnt_d;
            level_q   <= level_d;
            err_q     <= err_d;
        end
    end

    // A new-level request takes the READY cycle, so no query is granted alongside it.
    assign arb_en = (state_q == ST_READY) && !i_new_level;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .arst_n (arst_n),
        .i_req  (i_req),
        .i_en   (arb_en),
        .o_gnt  (gnt)
    );

    assign zone.o_zone_x = gnt[1] ? i_x1 : i_x0;
    assign zone.o_zone_y = gnt[1] ? i_y1 : i_y0;

    assign rsp_valid_d = gnt;
    assign rsp_safe_d  = (gnt != 2'b00) ? zone.i_zone_safe : rsp_safe_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rsp_valid_q <= 2'b00;
            rsp_safe_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_safe_q  <= rsp_safe_d;
        end
    end

    // Reset state is KICK, but the pulse must stay low while reset is still held.
    assign zone.o_regen = (state_q == ST_KICK) && arst_n;

    assign o_gnt       = gnt;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_safe  = rsp_safe_q;
    assign o_ready     = (state_q == ST_READY);
    assign o_level     = level_q;
    assign o_err       = err_q;
    assign o_dbg_state = szc_state_t'(state_q);
endmodule

// File: tb/tb_safe_zone_ctrl.sv
// Directed bench for safe_zone_ctrl with a small behavioural safe_zone model.
module tb_safe_zone_ctrl;
    import safe_zone_pkg::*;

    localparam int X_W  = $clog2(800);
    localparam int Y_W  = $clog2(600);
    localparam int BUSY = 5;

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic           i_new_level = 1'b0;
    logic [1:0]     i_req = 2'b00;
    logic [X_W-1:0] i_x0 = X_W'(10);
    logic [X_W-1:0] i_x1 = X_W'(30);
    logic [Y_W-1:0] i_y0 = Y_W'(20);
    logic [Y_W-1:0] i_y1 = Y_W'(40);
    logic [1:0]     o_gnt;
    logic [1:0]     o_rsp_valid;
    logic           o_rsp_safe;
    logic           o_ready;
    logic [7:0]     o_level;
    logic           o_err;
    szc_state_t     dbg_state;

    logic stuck_rdy = 1'b0;
    int   busy_cnt;
    int   errors = 0;
    int   checks = 0;

    safe_zone_ctrl_if #(.X_W(X_W), .Y_W(Y_W)) zif ();

    safe_zone_ctrl dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_new_level (i_new_level),
        .zone        (zif),
        .i_req       (i_req),
        .i_x0        (i_x0),
        .i_x1        (i_x1),
        .i_y0        (i_y0),
        .i_y1        (i_y1),
        .o_gnt       (o_gnt),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_safe  (o_rsp_safe),
        .o_ready     (o_ready),
        .o_level     (o_level),
        .o_err       (o_err),
        .o_dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // safe_zone model: ready drops for BUSY cycles after each kick; x < 25 is safe.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_cnt <= 0;
        end else if (zif.o_regen && !stuck_rdy) begin
            busy_cnt <= BUSY;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign zif.i_zone_rdy  = stuck_rdy || (busy_cnt == 0);
    assign zif.i_zone_safe = (zif.o_zone_x < X_W'(25));

    // Driver / checker tasks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_ready(input int max_cyc, output int cyc, output int regens,
                                output int bad_gnt);
        cyc = 0;
        regens = 0;
        bad_gnt = 0;
        while (!o_ready && cyc < max_cyc) begin
            if (zif.o_regen) regens++;
            if (o_gnt != 2'b00) bad_gnt++;
            next();
            cyc++;
        end
        chk("reached_ready", 32'(o_ready), 32'd1);
    endtask

    typedef struct {
        logic           nl;
        logic [1:0]     req;
        logic [1:0]     gnt;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [1:0]     rv;
        logic           rs;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int cyc, regens, bad_gnt;

        vecs[0] = '{1'b0, 2'b11, 2'b01, X_W'(10), Y_W'(20), 2'b00, 1'b0};
        vecs[1] = '{1'b0, 2'b11, 2'b10, X_W'(30), Y_W'(40), 2'b01, 1'b1};
        vecs[2] = '{1'b0, 2'b11, 2'b01, X_W'(10), Y_W'(20), 2'b10, 1'b0};
        vecs[3] = '{1'b0, 2'b11, 2'b10, X_W'(30), Y_W'(40), 2'b01, 1'b1};
        vecs[4] = '{1'b0, 2'b00, 2'b00, X_W'(10), Y_W'(20), 2'b10, 1'b0};
        vecs[5] = '{1'b0, 2'b10, 2'b10, X_W'(30), Y_W'(40), 2'b00, 1'b0};
        vecs[6] = '{1'b0, 2'b01, 2'b01, X_W'(10), Y_W'(20), 2'b10, 1'b0};
        vecs[7] = '{1'b0, 2'b11, 2'b10, X_W'(30), Y_W'(40), 2'b01, 1'b1};
        vecs[8] = '{1'b0, 2'b00, 2'b00, X_W'(10), Y_W'(20), 2'b10, 1'b0};
        vecs[9] = '{1'b1, 2'b01, 2'b00, X_W'(10), Y_W'(20), 2'b00, 1'b0};

        // Reset values while reset is held, with both ports requesting
        i_req = 2'b11;
        repeat (2) next();
        chk("rst_regen", 32'(zif.o_regen), 32'd0);
        chk("rst_gnt", 32'(o_gnt), 32'd0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_safe", 32'(o_rsp_safe), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);

        // Bring-up: KICK right after release, ready after seven edges
        arst_n = 1'b1;
        #1;
        run_to_ready(50, cyc, regens, bad_gnt);
        chk("boot_cycles", 32'(cyc), 32'd7);
        chk("boot_regens", 32'(regens), 32'd1);
        chk("boot_no_gnt", 32'(bad_gnt), 32'd0);
        chk("boot_level", 32'(o_level), 32'd1);

        // Arbitration table, ending with a new-level / request collision
        for (int i = 0; i < 10; i++) begin
            i_new_level = vecs[i].nl;
            i_req = vecs[i].req;
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(o_gnt), 32'(vecs[i].gnt));
            chk($sformatf("v%0d_x", i), 32'(zif.o_zone_x), 32'(vecs[i].x));
            chk($sformatf("v%0d_y", i), 32'(zif.o_zone_y), 32'(vecs[i].y));
            chk($sformatf("v%0d_rsp_valid", i), 32'(o_rsp_valid), 32'(vecs[i].rv));
            chk($sformatf("v%0d_rsp_safe", i), 32'(o_rsp_safe), 32'(vecs[i].rs));
            chk($sformatf("v%0d_ready", i), 32'(o_ready), 32'd1);
            chk($sformatf("v%0d_regen", i), 32'(zif.o_regen), 32'd0);
            next();
        end

        // Collision: the held request waits for the whole regeneration
        i_new_level = 1'b0;
        #1;
        chk("coll_regen", 32'(zif.o_regen), 32'd1);
        chk("coll_kick_gnt", 32'(o_gnt), 32'd0);
        run_to_ready(50, cyc, regens, bad_gnt);
        chk("coll_cycles", 32'(cyc), 32'd7);
        chk("coll_no_gnt", 32'(bad_gnt), 32'd0);
        chk("coll_gnt", 32'(o_gnt), 32'h1);
        chk("coll_level", 32'(o_level), 32'd2);
        next();
        chk("coll_rsp_valid", 32'(o_rsp_valid), 32'h1);
        chk("coll_rsp_safe", 32'(o_rsp_safe), 32'd1);
        i_req = 2'b00;

        // Pending: two pulses during GEN give one re-kick
        i_new_level = 1'b1;
        next();
        i_new_level = 1'b0;
        chk("pend_regen", 32'(zif.o_regen), 32'd1);
        next();
        next();
        chk("pend_in_gen", 32'(dbg_state), 32'(GEN));
        i_new_level = 1'b1;
        next();
        i_new_level = 1'b0;
        next();
        i_new_level = 1'b1;
        next();
        i_new_level = 1'b0;
        run_to_ready(50, cyc, regens, bad_gnt);
        chk("pend_cycles", 32'(cyc), 32'd9);
        chk("pend_regens", 32'(regens), 32'd1);
        chk("pend_level", 32'(o_level), 32'd4);

        // Arm timeout: ready never drops after the kick
        stuck_rdy = 1'b1;
        i_new_level = 1'b1;
        next();
        i_new_level = 1'b0;
        next();
        chk("arm_state", 32'(dbg_state), 32'(ARM));
        next();
        next();
        next();
        chk("arm_last_state", 32'(dbg_state), 32'(ARM));
        chk("arm_err_before", 32'(o_err), 32'd0);
        next();
        chk("arm_ready", 32'(o_ready), 32'd1);
        chk("arm_err", 32'(o_err), 32'd1);
        chk("arm_level", 32'(o_level), 32'd5);
        i_req = 2'b01;
        #1;
        chk("arm_post_gnt", 32'(o_gnt), 32'h1);
        next();
        i_req = 2'b00;
        chk("arm_post_rsp_safe", 32'(o_rsp_safe), 32'd1);
        repeat (3) next();
        chk("arm_err_sticky", 32'(o_err), 32'd1);
        stuck_rdy = 1'b0;

        // Reset during GEN
        i_new_level = 1'b1;
        next();
        i_new_level = 1'b0;
        next();
        next();
        chk("mid_in_gen", 32'(dbg_state), 32'(GEN));
        i_req = 2'b11;
        #2;
        arst_n = 1'b0;
        #1;
        chk("mid_regen", 32'(zif.o_regen), 32'd0);
        chk("mid_gnt", 32'(o_gnt), 32'd0);
        chk("mid_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("mid_rsp_safe", 32'(o_rsp_safe), 32'd0);
        chk("mid_level", 32'(o_level), 32'd0);
        chk("mid_err", 32'(o_err), 32'd0);
        chk("mid_state", 32'(dbg_state), 32'(KICK));
        next();
        arst_n = 1'b1;
        #1;
        chk("mid_rekick", 32'(zif.o_regen), 32'd1);
        run_to_ready(50, cyc, regens, bad_gnt);
        chk("mid_cycles", 32'(cyc), 32'd7);
        chk("mid_no_gnt", 32'(bad_gnt), 32'd0);
        chk("mid_level_after", 32'(o_level), 32'd1);
        chk("mid_err_after", 32'(o_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
